// File: rtl/neo_pkg.sv
// Shared types and constants for the NeoPixel frame sequencer.
package neo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      XMIT = 2'd3
   } state_t;

   localparam int NUM_COLORS = 3;

   localparam logic [1:0] COLOR_G = 2'd0;
   localparam logic [1:0] COLOR_R = 2'd1;
   localparam logic [1:0] COLOR_B = 2'd2;

   typedef logic [7:0] level_t;

endpackage

// File: rtl/neo_frame_buffer.sv
// Staging and active colour buffers. The host writes staging at any time;
// copy_i snapshots staging (including a write in the same cycle) into active,
// which is what the sequencer replays to the strand.
module neo_frame_buffer
   import neo_pkg::*;
#(
   parameter int NUM_PIXELS = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_en_i,
   input  logic [2:0] wr_pixel_i,
   input  logic [1:0] wr_color_i,
   input  level_t     wr_level_i,
   input  logic       copy_i,
   input  logic [2:0] rd_pix_i,
   input  logic [1:0] rd_col_i,
   output level_t     rd_level_o
);

   level_t staging_q [NUM_PIXELS][NUM_COLORS];
   level_t staging_d [NUM_PIXELS][NUM_COLORS];
   level_t active_q  [NUM_PIXELS][NUM_COLORS];

   // Next staging contents; out-of-range pixel or colour matches no entry and is dropped
   always_comb begin
      staging_d = staging_q;
      for (int p = 0; p < NUM_PIXELS; p++) begin
         for (int c = 0; c < NUM_COLORS; c++) begin
            if (wr_en_i && (wr_pixel_i == 3'(p)) && (wr_color_i == 2'(c))) begin
               staging_d[p][c] = wr_level_i;
            end
         end
      end
   end

   // Buffer registers; active takes the post-write staging image on copy
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PIXELS; p++) begin
            for (int c = 0; c < NUM_COLORS; c++) begin
               staging_q[p][c] <= '0;
               active_q[p][c]  <= '0;
            end
         end
      end else begin
         staging_q <= staging_d;
         if (copy_i) begin
            active_q <= staging_d;
         end
      end
   end

   // Read mux of the active frame by (pixel, colour)
   always_comb begin
      rd_level_o = '0;
      for (int p = 0; p < NUM_PIXELS; p++) begin
         for (int c = 0; c < NUM_COLORS; c++) begin
            if ((rd_pix_i == 3'(p)) && (rd_col_i == 2'(c))) begin
               rd_level_o = active_q[p][c];
            end
         end
      end
   end

endmodule

// File: rtl/neo_frame_sequencer.sv
// Frame-level controller: replays the committed frame into the strand one
// colour at a time, then requests transmission.
// Optional feature macro: NEO_AUTO_REFRESH_EN (periodic re-send of the active frame).
// Handshake: load_color pulses only in a cycle where ready_to_load is high
// (the strand takes the presented indices/level that cycle); send_it pulses
// only in a cycle where ready_to_send is high. The two never coincide.
module neo_frame_sequencer
   import neo_pkg::*;
#(
   parameter int NUM_PIXELS     = 5,
   parameter int REFRESH_CYCLES = 750000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_pixel,
   input  logic [1:0] wr_color,
   input  logic [7:0] wr_level,
   input  logic       commit,
   input  logic       ready_to_load,
   input  logic       ready_to_send,
   output logic [2:0] pixel_index,
   output logic [1:0] color_index,
   output logic [7:0] color_level,
   output logic       load_color,
   output logic       send_it,
   output logic       busy,
   output logic       frame_done,
   output logic [1:0] state_dbg
);

   localparam logic [2:0] LAST_PIX = 3'(NUM_PIXELS - 1);

   state_t     state_q, state_d;
   logic [2:0] pix_q, pix_d;
   logic [1:0] col_q, col_d;
   logic       pending_q, pending_d;
   logic       seen_low_q, seen_low_d;
   logic       copy;
   logic       refresh_fire;
   level_t     rd_level;

   neo_frame_buffer #(
      .NUM_PIXELS (NUM_PIXELS)
   ) u_buffer (
      .clock      (clock),
      .reset      (reset),
      .wr_en_i    (wr_en),
      .wr_pixel_i (wr_pixel),
      .wr_color_i (wr_color),
      .wr_level_i (wr_level),
      .copy_i     (copy),
      .rd_pix_i   (pix_q),
      .rd_col_i   (col_q),
      .rd_level_o (rd_level)
   );

`ifdef NEO_AUTO_REFRESH_EN
   localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

   logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;

   // Idle-time counter; restarts from zero whenever the FSM leaves IDLE
   always_comb begin
      refresh_cnt_d = '0;
      if ((state_q == IDLE) && (state_d == IDLE)) begin
         refresh_cnt_d = refresh_cnt_q + 1'b1;
      end
   end

   // Refresh counter register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         refresh_cnt_q <= '0;
      end else begin
         refresh_cnt_q <= refresh_cnt_d;
      end
   end

   assign refresh_fire = (state_q == IDLE) && (refresh_cnt_q == CNT_LAST);
`else
   logic unused_refresh_cycles;
   assign unused_refresh_cycles = (REFRESH_CYCLES > 0);
   assign refresh_fire          = 1'b0;
`endif

   // Sequencer state, load cursor, pending-commit and send-release flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pix_q      <= '0;
         col_q      <= COLOR_G;
         pending_q  <= 1'b0;
         seen_low_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pix_q      <= pix_d;
         col_q      <= col_d;
         pending_q  <= pending_d;
         seen_low_q <= seen_low_d;
      end
   end

   // Next-state and strobe logic
   always_comb begin
      state_d    = state_q;
      pix_d      = pix_q;
      col_d      = col_q;
      pending_d  = pending_q;
      seen_low_d = seen_low_q;
      copy       = 1'b0;
      load_color = 1'b0;
      send_it    = 1'b0;
      frame_done = 1'b0;

      // Any number of commits during a frame collapse into one follow-up frame
      if ((state_q != IDLE) && commit) begin
         pending_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (commit || pending_q) begin
               copy      = 1'b1;
               pending_d = 1'b0;
               pix_d     = '0;
               col_d     = COLOR_G;
               state_d   = LOAD;
            end else if (refresh_fire) begin
               pix_d   = '0;
               col_d   = COLOR_G;
               state_d = LOAD;
            end
         end
         LOAD: begin
            load_color = ready_to_load;
            if (ready_to_load) begin
               if (col_q == COLOR_B) begin
                  col_d = COLOR_G;
                  if (pix_q == LAST_PIX) begin
                     state_d = SEND;
                  end else begin
                     pix_d = pix_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         SEND: begin
            if (ready_to_send) begin
               send_it    = 1'b1;
               seen_low_d = 1'b0;
               state_d    = XMIT;
            end
         end
         XMIT: begin
            // Strand must first drop ready_to_send, then become loadable again
            if (!ready_to_send) begin
               seen_low_d = 1'b1;
            end
            if ((seen_low_q || !ready_to_send) && ready_to_load) begin
               frame_done = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pixel_index = (state_q == LOAD) ? pix_q    : 3'd0;
   assign color_index = (state_q == LOAD) ? col_q    : 2'd0;
   assign color_level = (state_q == LOAD) ? rd_level : 8'd0;
   assign busy        = (state_q != IDLE);
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// Testbench for neo_frame_sequencer: scoreboard of expected strand loads.
module tb_neo_frame_sequencer;

   localparam int NP = 5;
   localparam int RC = 20;

   logic       clock = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_pixel;
   logic [1:0] wr_color;
   logic [7:0] wr_level;
   logic       commit;
   logic       ready_to_load;
   logic       ready_to_send;
   logic [2:0] pixel_index;
   logic [1:0] color_index;
   logic [7:0] color_level;
   logic       load_color;
   logic       send_it;
   logic       busy;
   logic       frame_done;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;
   int load_count = 0;
   int send_count = 0;
   int done_count = 0;

   logic [12:0] exp_q[$];
   logic [7:0]  stage_m  [NP][3];
   logic [7:0]  active_m [NP][3];

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   neo_frame_sequencer #(
      .NUM_PIXELS     (NP),
      .REFRESH_CYCLES (RC)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .wr_en         (wr_en),
      .wr_pixel      (wr_pixel),
      .wr_color      (wr_color),
      .wr_level      (wr_level),
      .commit        (commit),
      .ready_to_load (ready_to_load),
      .ready_to_send (ready_to_send),
      .pixel_index   (pixel_index),
      .color_index   (color_index),
      .color_level   (color_level),
      .load_color    (load_color),
      .send_it       (send_it),
      .busy          (busy),
      .frame_done    (frame_done),
      .state_dbg     (state_dbg)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      #2;
      if (reset === 1'b1) begin
         if (load_color || send_it) begin
            checks++;
            if (load_color && send_it) begin
               errors++;
               $display("FAIL strobe_overlap: load_color=%b send_it=%b, required not both", load_color, send_it);
            end
         end
         if (state_dbg == 2'd1) begin
            checks++;
            if (load_color !== ready_to_load) begin
               errors++;
               $display("FAIL load_gate: load_color=%b, required %b", load_color, ready_to_load);
            end
            if (exp_q.size() == 0) begin
               if (load_color) begin
                  checks++;
                  errors++;
                  $display("FAIL load_unexpected: load of (%0d,%0d)=%h with nothing expected",
                           pixel_index, color_index, color_level);
               end
            end else begin
               checks++;
               if ({pixel_index, color_index, color_level} !== exp_q[0]) begin
                  errors++;
                  $display("FAIL load_data: got (%0d,%0d)=%h, required (%0d,%0d)=%h",
                           pixel_index, color_index, color_level,
                           exp_q[0][12:10], exp_q[0][9:8], exp_q[0][7:0]);
               end
            end
            if (load_color) begin
               load_count++;
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
         end
         if (send_it) begin
            send_count++;
            checks++;
            if (ready_to_send !== 1'b1) begin
               errors++;
               $display("FAIL send_gate: send_it=1 with ready_to_send=%b, required 1", ready_to_send);
            end
         end
         if (frame_done) done_count++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      wr_en         = 1'b0;
      wr_pixel      = 3'd0;
      wr_color      = 2'd0;
      wr_level      = 8'd0;
      commit        = 1'b0;
      ready_to_load = 1'b1;
      ready_to_send = 1'b0;
   endtask

   task automatic model_clear();
      for (int p = 0; p < NP; p++)
         for (int c = 0; c < 3; c++) begin
            stage_m[p][c]  = 8'd0;
            active_m[p][c] = 8'd0;
         end
   endtask

   task automatic model_write(input int p, input int c, input logic [7:0] l);
      if (p < NP && c < 3) stage_m[p][c] = l;
   endtask

   task automatic push_frame();
      for (int p = 0; p < NP; p++)
         for (int c = 0; c < 3; c++)
            exp_q.push_back({3'(p), 2'(c), active_m[p][c]});
   endtask

   task automatic model_commit();
      active_m = stage_m;
      push_frame();
   endtask

   // one cycle of write and/or commit, then release both
   task automatic drive_cycle(input logic we, input logic [2:0] p, input logic [1:0] c,
                              input logic [7:0] l, input logic cm);
      @(negedge clock);
      wr_en    = we;
      wr_pixel = p;
      wr_color = c;
      wr_level = l;
      commit   = cm;
      if (we) model_write(int'(p), int'(c), l);
      @(negedge clock);
      wr_en  = 1'b0;
      commit = 1'b0;
   endtask

   // strand behaviour for one frame; optionally commits twice during XMIT
   task automatic run_frame(input bit toggle, input bit xmit_commits);
      int  start_done = done_count;
      int  start_send = send_count;
      int  start_load = load_count;
      int  budget     = 0;
      int  after_send = 0;
      bit  phase      = 1'b0;
      while (done_count == start_done && budget < 300) begin
         @(negedge clock);
         budget++;
         wr_en  = 1'b0;
         commit = 1'b0;
         if (send_count == start_send) begin
            phase         = ~phase;
            ready_to_load = toggle ? phase : 1'b1;
            ready_to_send = (load_count - start_load >= 15);
         end else begin
            after_send++;
            ready_to_send = 1'b0;
            ready_to_load = (after_send > 4);
            if (xmit_commits) begin
               case (after_send)
                  1: commit = 1'b1;
                  2: begin
                     wr_en    = 1'b1;
                     wr_pixel = 3'd0;
                     wr_color = 2'd2;
                     wr_level = 8'h3C;
                     model_write(0, 2, 8'h3C);
                  end
                  3: commit = 1'b1;
                  default: ;
               endcase
            end
         end
      end
      checks++;
      if (done_count == start_done) begin
         errors++;
         $display("FAIL frame_timeout: no frame_done within %0d cycles", budget);
      end
      checks++;
      if (load_count - start_load !== 15) begin
         errors++;
         $display("FAIL load_total: %0d loads, required 15", load_count - start_load);
      end
      checks++;
      if (send_count - start_send !== 1) begin
         errors++;
         $display("FAIL send_total: %0d sends, required 1", send_count - start_send);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL exp_left: %0d expected loads outstanding, required 0", exp_q.size());
      end
      exp_q.delete();
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_done: busy=%b, required 0", busy);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int loads_before;
      #1;
      checks++;
      if ({pixel_index, color_index, color_level, load_color, send_it, busy, frame_done} !== 17'd0) begin
         errors++;
         $display("FAIL reset_initial: outputs=%h, required 0",
                  {pixel_index, color_index, color_level, load_color, send_it, busy, frame_done});
      end
      @(negedge clock);
      reset = 1'b1;
      drive_cycle(1'b1, 3'd1, 2'd0, 8'h77, 1'b0);
      drive_cycle(1'b0, 3'd0, 2'd0, 8'h00, 1'b1);
      model_commit();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({pixel_index, color_index, color_level} !== 13'd0) begin
         errors++;
         $display("FAIL reset_mid_index: (%0d,%0d)=%h, required 0", pixel_index, color_index, color_level);
      end
      checks++;
      if ({load_color, send_it, frame_done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_strobes: load=%b send=%b done=%b, required 0", load_color, send_it, frame_done);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_busy: busy=%b, required 0", busy);
      end
      model_clear();
      exp_q.delete();
      @(negedge clock);
      reset = 1'b1;
      loads_before = load_count;
      repeat (5) begin
         @(negedge clock);
         #1;
         checks++;
         if (busy !== 1'b0 || load_color !== 1'b0 || send_it !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b load=%b send=%b, required 0", busy, load_color, send_it);
         end
      end
      checks++;
      if (load_count !== loads_before) begin
         errors++;
         $display("FAIL post_reset_loads: %0d loads, required 0", load_count - loads_before);
      end
   endtask

   task automatic test_single_frame();
      drive_cycle(1'b1, 3'd2, 2'd1, 8'hA5, 1'b0);
      drive_cycle(1'b0, 3'd0, 2'd0, 8'h00, 1'b1);
      model_commit();
      run_frame(1'b0, 1'b0);
   endtask

   task automatic test_load_stall();
      for (int i = 0; i < 4; i++)
         drive_cycle(1'b1, 3'($urandom_range(0, NP - 1)), 2'($urandom_range(0, 2)),
                     8'($urandom_range(1, 255)), 1'b0);
      drive_cycle(1'b0, 3'd0, 2'd0, 8'h00, 1'b1);
      model_commit();
      run_frame(1'b1, 1'b0);
   endtask

   task automatic test_pending_commit();
      int loads_before;
      drive_cycle(1'b0, 3'd0, 2'd0, 8'h00, 1'b1);
      model_commit();
      run_frame(1'b0, 1'b1);
      model_commit();
      run_frame(1'b0, 1'b0);
      checks++;
      if (active_m[0][2] !== 8'h3C) begin
         errors++;
         $display("FAIL pending_model: (0,2)=%h, required 3c", active_m[0][2]);
      end
      loads_before = load_count;
      repeat (8) begin
         @(negedge clock);
         #1;
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL pending_collapse: busy=%b after extra frame, required 0", busy);
         end
      end
      checks++;
      if (load_count !== loads_before) begin
         errors++;
         $display("FAIL pending_extra_loads: %0d loads, required 0", load_count - loads_before);
      end
   endtask

   task automatic test_write_commit_same_cycle();
      drive_cycle(1'b1, 3'd6, 2'd0, 8'hEE, 1'b1);
      model_commit();
      run_frame(1'b0, 1'b0);
      drive_cycle(1'b1, 3'd1, 2'd3, 8'hDD, 1'b1);
      model_commit();
      run_frame(1'b0, 1'b0);
      drive_cycle(1'b1, 3'd4, 2'd2, 8'h5A, 1'b1);
      model_commit();
      run_frame(1'b0, 1'b0);
   endtask

`ifdef NEO_AUTO_REFRESH_EN
   task automatic test_auto_refresh();
      int idle    = 1;
      bit started = 1'b0;
      for (int i = 0; i < 40 && !started; i++) begin
         @(negedge clock);
         if (i == 0) begin
            wr_en    = 1'b1;
            wr_pixel = 3'd3;
            wr_color = 2'd0;
            wr_level = 8'h99;
            model_write(3, 0, 8'h99);
         end else begin
            wr_en = 1'b0;
         end
         #1;
         if (busy) started = 1'b1;
         else idle++;
      end
      checks++;
      if (!started || idle != RC) begin
         errors++;
         $display("FAIL refresh_timing: started=%b after %0d idle cycles, required 1 after %0d", started, idle, RC);
      end
      if (started) begin
         push_frame();
         run_frame(1'b0, 1'b0);
      end
   endtask
`endif

   initial begin
      reset = 1'b0;
      clear_inputs();
      model_clear();
      test_reset();
      test_single_frame();
      test_load_stall();
      test_pending_commit();
      test_write_commit_same_cycle();
`ifdef NEO_AUTO_REFRESH_EN
      test_auto_refresh();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
